// File: rtl/alu_div_pkg.sv
// Shared definitions for the ALU divide path: FSM encoding, default width
// and the result rule used when the divisor is zero.
package alu_div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 16;
   localparam int DIV_MAX_WIDTH     = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_BUSY = BUSY;
   localparam logic [1:0] ST_DONE = DONE;

   // Divide-by-zero yields an all-ones quotient of the requested width.
   function automatic logic [DIV_MAX_WIDTH-1:0] div0_quotient(input int width);
      return {DIV_MAX_WIDTH{1'b1}} >> (DIV_MAX_WIDTH - width);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {PR,Q} left, trial-subtract the
// divisor and keep the difference when it is non-negative.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   i_pr,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_pr,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH+1:0] w_shifted;
   logic [WIDTH+1:0] w_sub_b;
   logic [WIDTH+1:0] w_diff;
   logic             w_neg;

   // Subtract as add of the inverted divisor with carry-in 1, so this adder
   // can later be replaced by the lookahead adder. One guard bit above the
   // partial remainder makes the sign bit unambiguous.
   assign w_shifted = {i_pr, i_q[WIDTH-1]};
   assign w_sub_b   = ~{2'b00, i_divisor};
   assign w_diff    = w_shifted + w_sub_b + (WIDTH+2)'(1);
   assign w_neg     = w_diff[WIDTH+1];

   assign o_pr = w_neg ? w_shifted[WIDTH:0] : w_diff[WIDTH:0];
   assign o_q  = {i_q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready request and
// response handshakes; one quotient bit is produced per clock.
module seq_divider
   import alu_div_pkg::*;
#(
   parameter  int WIDTH = DIV_WIDTH_DEFAULT,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [WIDTH-1:0] DIV0_Q    = WIDTH'(div0_quotient(WIDTH));
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH:0]   r_pr;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_divisor;
   logic             r_dbz;

   logic [WIDTH:0]   w_next_pr;
   logic [WIDTH-1:0] w_next_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_pr      (r_pr),
      .i_q       (r_q),
      .i_divisor (r_divisor),
      .o_pr      (w_next_pr),
      .o_q       (w_next_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_pr      <= '0;
         r_q       <= '0;
         r_divisor <= '0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_valid) begin
                  r_divisor <= divisor;
                  r_count   <= '0;
                  // A zero divisor skips iteration and reports immediately.
                  if (divisor == '0) begin
                     r_q     <= DIV0_Q;
                     r_pr    <= {1'b0, dividend};
                     r_dbz   <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_q     <= dividend;
                     r_pr    <= '0;
                     r_dbz   <= 1'b0;
                     r_state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               r_pr    <= w_next_pr;
               r_q     <= w_next_q;
               r_count <= r_count + CNT_W'(1);
               if (r_count == LAST_STEP) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign start_ready = (r_state == ST_IDLE);
   assign res_valid   = (r_state == ST_DONE);
   assign quotient    = r_q;
   assign remainder   = r_pr[WIDTH-1:0];
   assign div_by_zero = r_dbz;

endmodule
